// File: rtl/systolic_ctrl.sv
// systolic_ctrl: sequencer for a 3x3 weight-stationary systolic array.
// Loads nine weights, streams activation vectors into the west row inputs
// with per-row skew, and tracks per-column result validity at the south edge.
// Optional build macro SYSTOLIC_CTRL_PERF_EN adds the stall_cnt output.
module systolic_ctrl #(
  parameter  int DW   = 32,
  parameter  int MAXV = 16,
  localparam int NW   = $clog2(MAXV + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [NW-1:0]   cfg_nvec,
  input  logic [9*DW-1:0] w_in,
  input  logic            act_valid,
  output logic            act_ready,
  input  logic [3*DW-1:0] act_data,
  output logic [9*DW-1:0] w_out,
  output logic            weight_en,
  output logic            compute,
  output logic [DW-1:0]   west0,
  output logic [DW-1:0]   west3,
  output logic [DW-1:0]   west6,
  output logic [2:0]      col_valid,
  output logic            busy,
  output logic            done
`ifdef SYSTOLIC_CTRL_PERF_EN
  ,
  output logic [15:0]     stall_cnt
`endif
);

  localparam logic [NW-1:0] MAXV_N = NW'(MAXV);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t        state;
  logic [NW-1:0] remaining;
  logic [2:0]    drain_cnt;
  logic          accept;

  // Skew stages for rows 1 and 2, and the accepted-vector token shift chain.
  logic [DW-1:0] row1_d;
  logic [DW-1:0] row2_d0;
  logic [DW-1:0] row2_d1;
  logic [5:0]    tok;

  assign act_ready = (state == S_STREAM) && (remaining != '0);
  // A vector presented in the abort cycle is dropped along with the job.
  assign accept    = act_ready && act_valid && !abort;

  // Job sequencing FSM with registered strobes and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      remaining <= '0;
      drain_cnt <= '0;
      w_out     <= '0;
      weight_en <= 1'b0;
      compute   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (abort) begin
      state     <= S_IDLE;
      remaining <= '0;
      drain_cnt <= '0;
      weight_en <= 1'b0;
      compute   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      weight_en <= 1'b0;
      done      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            remaining <= (cfg_nvec > MAXV_N) ? MAXV_N : cfg_nvec;
            w_out     <= w_in;
            weight_en <= 1'b1;
            busy      <= 1'b1;
            state     <= S_LOAD_W;
          end
        end
        S_LOAD_W: begin
          if (remaining == '0) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            compute <= 1'b1;
            state   <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (accept) begin
            remaining <= remaining - NW'(1);
            if (remaining == NW'(1)) begin
              // Six drain cycles cover the last token reaching column 2.
              drain_cnt <= 3'd5;
              state     <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (drain_cnt == '0) begin
            compute <= 1'b0;
            done    <= 1'b1;
            state   <= S_DONE;
          end else begin
            drain_cnt <= drain_cnt - 3'd1;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Row skew registers and validity tokens; bubbles shift zeros through.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      west0   <= '0;
      row1_d  <= '0;
      west3   <= '0;
      row2_d0 <= '0;
      row2_d1 <= '0;
      west6   <= '0;
      tok     <= '0;
    end else if (abort) begin
      west0   <= '0;
      row1_d  <= '0;
      west3   <= '0;
      row2_d0 <= '0;
      row2_d1 <= '0;
      west6   <= '0;
      tok     <= '0;
    end else begin
      west0   <= accept ? act_data[0 +: DW] : '0;
      row1_d  <= accept ? act_data[DW +: DW] : '0;
      west3   <= row1_d;
      row2_d0 <= accept ? act_data[2*DW +: DW] : '0;
      row2_d1 <= row2_d0;
      west6   <= row2_d1;
      tok     <= {tok[4:0], accept};
    end
  end

  // Token reaches column c's south output 4+c cycles after acceptance.
  assign col_valid = tok[5:3];

`ifdef SYSTOLIC_CTRL_PERF_EN
  // Saturating count of streaming cycles starved by the upstream source.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if ((state == S_IDLE) && start && !abort) begin
      stall_cnt <= '0;
    end else if (act_ready && !act_valid && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule
